csh_cyc_arb: RTL and testbench
==============================

Name: csh_cyc_arb

Overview:
- Cache cycle arbiter/sequencer feeding the physical memory address path.
- Arbitrates between the EBOX, CHAN and CCA (cache-clear sweep) requesters and grants the cache to one of them.
- Sequences each granted cycle through lookup, victim writeback, page refill and line fill.
- Produces the grant, READY_TO_GO, WRITEBACK_T2 and PAGE_REFILL_T4 timing that PMA uses to steer PA source selects and hold its cycle-type registers.

Parameters:
- FILL_WORDS, 4: words per line fill; data beats counted before DONE.
- STARVE_LIMIT, 8: consecutive EBOX wins while CCA waits before CCA is forced.
- MEM_TIMEOUT, 255: cycles in any memory wait before NXM_ERR; 8-bit counter.

Ports:
- CLK  in  1  clock. Single domain.
- RESET_n  in  1  asynchronous, active-low reset.
- EBOX_REQ  in  1  EBOX cycle request; held until EBOX_DONE.
- CHAN_REQ  in  1  channel cycle request; held until CHAN_DONE.
- CCA_REQ  in  1  sweep cycle request; held until CCA_DONE.
- CSH_HIT  in  1  lookup hit, valid in LOOKUP.
- VICTIM_DIRTY  in  1  victim line dirty, valid in LOOKUP.
- PAGE_MISS  in  1  page table entry invalid, valid in LOOKUP; meaningful for EBOX only.
- MEM_ACK  in  1  memory accepted writeback.
- MEM_DATA_VALID  in  1  read data beat present.
- EBOX_REQ_GRANT, CHAN_REQ_GRANT, CCA_REQ_GRANT  out  1 each  one-cycle grant pulses.
- READY_TO_GO  out  1  high in GRANT cycle only.
- WRITEBACK_T2  out  1  high in WB_T2.
- PAGE_REFILL_T4  out  1  high in RF_T4.
- MEM_START  out  1  one-cycle memory start pulse.
- MEM_WRITE  out  1  qualifies MEM_START (1 = writeback).
- PT_WRITE  out  1  one-cycle page-table load pulse in RF_T5.
- EBOX_DONE, CHAN_DONE, CCA_DONE  out  1 each  one-cycle completion pulses.
- PAGE_FAIL  out  1  accompanies EBOX_DONE when a retry still misses.
- NXM_ERR  out  1  accompanies DONE on memory timeout.
- BUSY  out  1  state != IDLE.
- OWNER  out  2  00 none, 01 EBOX, 10 CHAN, 11 CCA.

Behaviour:
- Reset (async, RESET_n=0): state IDLE; all outputs 0; OWNER=00; starve, beat, timeout and retry counters cleared. Reset mid-cycle abandons the cycle with no DONE pulse.
- States: IDLE, GRANT, LOOKUP, WB_T1, WB_T2, WB_WAIT, FILL_WAIT, RF_T1, RF_T2, RF_T3, RF_T4, RF_WAIT, RF_T5, DONE.
- IDLE: when any request is present, latch the winner into OWNER and go to GRANT.
- Priority: CHAN > EBOX > CCA.
- Starvation guard: the starve counter increments on each EBOX win while CCA_REQ=1. It clears on a CCA win or when CCA_REQ=0. When it equals STARVE_LIMIT and CCA_REQ=1, CCA wins over EBOX. CHAN still wins.
- GRANT (1 cycle): READY_TO_GO=1; the owner's *_REQ_GRANT=1. Next state LOOKUP. Request-to-grant latency is 1 cycle.
- LOOKUP decision order:
  1. Owner EBOX and PAGE_MISS: go to RF_T1.
  2. CSH_HIT: go to DONE.
  3. VICTIM_DIRTY: go to WB_T1.
  4. Owner CCA: go to DONE (sweep clean miss, no fill).
  5. Otherwise: MEM_START=1, MEM_WRITE=0, go to FILL_WAIT.
- WB_T1 → WB_T2. WB_T2: WRITEBACK_T2=1, MEM_START=1, MEM_WRITE=1, go to WB_WAIT.
- WB_WAIT: on MEM_ACK, owner CCA goes to DONE. Otherwise MEM_START=1, MEM_WRITE=0, go to FILL_WAIT.
- FILL_WAIT: count MEM_DATA_VALID beats. On beat FILL_WORDS go to DONE; the counter resets on exit.
- Page refill:
  - RF_T1 → RF_T2 → RF_T3 → RF_T4.
  - RF_T4: PAGE_REFILL_T4=1, MEM_START=1, MEM_WRITE=0, go to RF_WAIT.
  - RF_WAIT: one MEM_DATA_VALID goes to RF_T5.
  - RF_T5: PT_WRITE=1, set the retry flag, go to LOOKUP.
  - PAGE_MISS in LOOKUP with the retry flag set: PAGE_FAIL=1, go to DONE.
- Memory timeout: in WB_WAIT, FILL_WAIT and RF_WAIT the timeout counter increments each cycle without progress; it clears on entry and on each beat or ack. On reaching MEM_TIMEOUT, set NXM_ERR and go to DONE.
- DONE (1 cycle): the owner's *_DONE=1; PAGE_FAIL and NXM_ERR are presented only in this cycle. Clear OWNER and the retry flag, go to IDLE. There is at least one IDLE cycle between cycles.
- Request deasserted mid-cycle: the cycle still completes. Requests arriving while BUSY wait in place. Simultaneous MEM_ACK and MEM_DATA_VALID outside the matching state are ignored.

Test Plan:
- Arbitration: EBOX_REQ and CHAN_REQ asserted in the same cycle, CSH_HIT=1 → CHAN_REQ_GRANT pulses in the cycle after assertion with READY_TO_GO=1. CHAN_DONE follows 2 cycles later. EBOX is granted in the cycle after the following IDLE.
- Dirty miss, EBOX: CSH_HIT=0, VICTIM_DIRTY=1, MEM_ACK after 3 cycles, 4 data beats → WRITEBACK_T2 high exactly 1 cycle. Two MEM_START pulses, MEM_WRITE=1 then 0. EBOX_DONE follows the 4th beat.
- Page refill: EBOX with PAGE_MISS=1, then 0 on retry with hit → PAGE_REFILL_T4 is high 4 cycles after LOOKUP. PT_WRITE pulses once. EBOX_DONE with PAGE_FAIL=0. Repeat with PAGE_MISS held at 1 → PAGE_FAIL=1 with EBOX_DONE.
- Starvation: CCA_REQ and EBOX_REQ held, all hits → 8 EBOX grants, then a CCA_REQ_GRANT, then EBOX again.
- Timeout: fill miss with no MEM_DATA_VALID → NXM_ERR and EBOX_DONE 255 cycles after MEM_START, then BUSY=0.
- Reset: RESET_n low during FILL_WAIT → all outputs 0 immediately with no DONE. After release, a fresh CHAN_REQ is granted normally.

Source files
------------

// File: rtl/csh_cyc_arb.sv
// Cache cycle arbiter/sequencer: grants the cache to CHAN, EBOX or CCA and walks the
// granted cycle through lookup, victim writeback, page refill and line fill for PMA.
module csh_cyc_arb #(
   parameter int FILL_WORDS   = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int MEM_TIMEOUT  = 255
) (
   input  logic       CLK,
   input  logic       RESET_n,
   input  logic       EBOX_REQ,
   input  logic       CHAN_REQ,
   input  logic       CCA_REQ,
   input  logic       CSH_HIT,
   input  logic       VICTIM_DIRTY,
   input  logic       PAGE_MISS,
   input  logic       MEM_ACK,
   input  logic       MEM_DATA_VALID,
   output logic       EBOX_REQ_GRANT,
   output logic       CHAN_REQ_GRANT,
   output logic       CCA_REQ_GRANT,
   output logic       READY_TO_GO,
   output logic       WRITEBACK_T2,
   output logic       PAGE_REFILL_T4,
   output logic       MEM_START,
   output logic       MEM_WRITE,
   output logic       PT_WRITE,
   output logic       EBOX_DONE,
   output logic       CHAN_DONE,
   output logic       CCA_DONE,
   output logic       PAGE_FAIL,
   output logic       NXM_ERR,
   output logic       BUSY,
   output logic [1:0] OWNER,
   output logic [3:0] dbg_state
);

   // Requests are levels: a requester raises *_REQ and holds it until its *_DONE pulse;
   // the one-cycle *_REQ_GRANT pulse marks acceptance, and a request seen while BUSY waits.

   typedef enum logic [3:0] {
      S_IDLE, S_GRANT, S_LOOKUP, S_WB_T1, S_WB_T2, S_WB_WAIT, S_FILL_WAIT,
      S_RF_T1, S_RF_T2, S_RF_T3, S_RF_T4, S_RF_WAIT, S_RF_T5, S_DONE
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_EBOX = 2'b01;
   localparam logic [1:0] OWN_CHAN = 2'b10;
   localparam logic [1:0] OWN_CCA  = 2'b11;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int BW = $clog2(FILL_WORDS + 1);

   state_t        state;
   logic [SW-1:0] starve_cnt;
   logic [BW-1:0] beat_cnt;
   logic [7:0]    tmo_cnt;
   logic          retry;
   logic [1:0]    winner;
   logic          tmo_hit;

   // {cca, chan, ebox} one-hot select for grant and done pulses
   function automatic logic [2:0] own_onehot(input logic [1:0] own);
      logic [2:0] v;
      v = 3'b000;
      case (own)
         OWN_EBOX: v = 3'b001;
         OWN_CHAN: v = 3'b010;
         OWN_CCA:  v = 3'b100;
         default:  v = 3'b000;
      endcase
      return v;
   endfunction

   always_comb begin
      winner = OWN_NONE;
      if (CHAN_REQ)
         winner = OWN_CHAN;
      else if (CCA_REQ && (!EBOX_REQ || starve_cnt == SW'(STARVE_LIMIT)))
         winner = OWN_CCA;
      else if (EBOX_REQ)
         winner = OWN_EBOX;
   end

   assign tmo_hit   = (tmo_cnt == 8'(MEM_TIMEOUT - 1));
   assign dbg_state = state;

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state          <= S_IDLE;
         starve_cnt     <= '0;
         beat_cnt       <= '0;
         tmo_cnt        <= '0;
         retry          <= 1'b0;
         EBOX_REQ_GRANT <= 1'b0;
         CHAN_REQ_GRANT <= 1'b0;
         CCA_REQ_GRANT  <= 1'b0;
         READY_TO_GO    <= 1'b0;
         WRITEBACK_T2   <= 1'b0;
         PAGE_REFILL_T4 <= 1'b0;
         MEM_START      <= 1'b0;
         MEM_WRITE      <= 1'b0;
         PT_WRITE       <= 1'b0;
         EBOX_DONE      <= 1'b0;
         CHAN_DONE      <= 1'b0;
         CCA_DONE       <= 1'b0;
         PAGE_FAIL      <= 1'b0;
         NXM_ERR        <= 1'b0;
         BUSY           <= 1'b0;
         OWNER          <= OWN_NONE;
      end else begin
         // Every output except BUSY/OWNER is a pulse for the state being entered.
         EBOX_REQ_GRANT <= 1'b0;
         CHAN_REQ_GRANT <= 1'b0;
         CCA_REQ_GRANT  <= 1'b0;
         READY_TO_GO    <= 1'b0;
         WRITEBACK_T2   <= 1'b0;
         PAGE_REFILL_T4 <= 1'b0;
         MEM_START      <= 1'b0;
         MEM_WRITE      <= 1'b0;
         PT_WRITE       <= 1'b0;
         EBOX_DONE      <= 1'b0;
         CHAN_DONE      <= 1'b0;
         CCA_DONE       <= 1'b0;
         PAGE_FAIL      <= 1'b0;
         NXM_ERR        <= 1'b0;
         if (!CCA_REQ)
            starve_cnt <= '0;

         case (state)
            S_IDLE: begin
               if (winner != OWN_NONE) begin
                  OWNER       <= winner;
                  BUSY        <= 1'b1;
                  READY_TO_GO <= 1'b1;
                  {CCA_REQ_GRANT, CHAN_REQ_GRANT, EBOX_REQ_GRANT} <= own_onehot(winner);
                  if (winner == OWN_EBOX && CCA_REQ)
                     starve_cnt <= starve_cnt + SW'(1);
                  else if (winner == OWN_CCA)
                     starve_cnt <= '0;
                  state <= S_GRANT;
               end
            end
            S_GRANT: state <= S_LOOKUP;
            S_LOOKUP: begin
               if (OWNER == OWN_EBOX && PAGE_MISS) begin
                  if (retry) begin
                     PAGE_FAIL <= 1'b1;
                     {CCA_DONE, CHAN_DONE, EBOX_DONE} <= own_onehot(OWNER);
                     state <= S_DONE;
                  end else begin
                     state <= S_RF_T1;
                  end
               end else if (CSH_HIT || (!VICTIM_DIRTY && OWNER == OWN_CCA)) begin
                  {CCA_DONE, CHAN_DONE, EBOX_DONE} <= own_onehot(OWNER);
                  state <= S_DONE;
               end else if (VICTIM_DIRTY) begin
                  state <= S_WB_T1;
               end else begin
                  MEM_START <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= S_FILL_WAIT;
               end
            end
            S_WB_T1: begin
               WRITEBACK_T2 <= 1'b1;
               MEM_START    <= 1'b1;
               MEM_WRITE    <= 1'b1;
               state        <= S_WB_T2;
            end
            S_WB_T2: begin
               tmo_cnt <= '0;
               state   <= S_WB_WAIT;
            end
            S_WB_WAIT: begin
               if (MEM_ACK) begin
                  tmo_cnt <= '0;
                  if (OWNER == OWN_CCA) begin
                     {CCA_DONE, CHAN_DONE, EBOX_DONE} <= own_onehot(OWNER);
                     state <= S_DONE;
                  end else begin
                     MEM_START <= 1'b1;
                     state     <= S_FILL_WAIT;
                  end
               end else if (tmo_hit) begin
                  NXM_ERR <= 1'b1;
                  {CCA_DONE, CHAN_DONE, EBOX_DONE} <= own_onehot(OWNER);
                  state <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            S_FILL_WAIT: begin
               if (MEM_DATA_VALID) begin
                  tmo_cnt <= '0;
                  if (beat_cnt == BW'(FILL_WORDS - 1)) begin
                     beat_cnt <= '0;
                     {CCA_DONE, CHAN_DONE, EBOX_DONE} <= own_onehot(OWNER);
                     state <= S_DONE;
                  end else begin
                     beat_cnt <= beat_cnt + BW'(1);
                  end
               end else if (tmo_hit) begin
                  beat_cnt <= '0;
                  NXM_ERR  <= 1'b1;
                  {CCA_DONE, CHAN_DONE, EBOX_DONE} <= own_onehot(OWNER);
                  state <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            S_RF_T1: state <= S_RF_T2;
            S_RF_T2: state <= S_RF_T3;
            S_RF_T3: begin
               PAGE_REFILL_T4 <= 1'b1;
               MEM_START      <= 1'b1;
               state          <= S_RF_T4;
            end
            S_RF_T4: begin
               tmo_cnt <= '0;
               state   <= S_RF_WAIT;
            end
            S_RF_WAIT: begin
               if (MEM_DATA_VALID) begin
                  tmo_cnt  <= '0;
                  PT_WRITE <= 1'b1;
                  state    <= S_RF_T5;
               end else if (tmo_hit) begin
                  NXM_ERR <= 1'b1;
                  {CCA_DONE, CHAN_DONE, EBOX_DONE} <= own_onehot(OWNER);
                  state <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            S_RF_T5: begin
               retry <= 1'b1;
               state <= S_LOOKUP;
            end
            S_DONE: begin
               OWNER <= OWN_NONE;
               BUSY  <= 1'b0;
               retry <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csh_cyc_arb.sv
// Bench for csh_cyc_arb: a transaction-level timeline model predicts every output cycle by
// cycle and drives the memory side from the same timeline.
module tb_csh_cyc_arb;

   localparam int MAXC = 320;
   localparam int OW   = 17;
   localparam int STARVE_LIMIT = 8;
   localparam int B_EG = 16, B_CG = 15, B_AG = 14, B_RTG = 13, B_WB = 12, B_RF = 11;
   localparam int B_MS = 10, B_MW = 9, B_PT = 8, B_ED = 7, B_CD = 6, B_AD = 5;
   localparam int B_PF = 4, B_NX = 3, B_BUSY = 2;
   localparam logic [1:0] OWN_NONE = 2'b00, OWN_EBOX = 2'b01, OWN_CHAN = 2'b10, OWN_CCA = 2'b11;

   logic CLK, RESET_n;
   logic EBOX_REQ, CHAN_REQ, CCA_REQ, CSH_HIT, VICTIM_DIRTY, PAGE_MISS, MEM_ACK, MEM_DATA_VALID;
   logic EBOX_REQ_GRANT, CHAN_REQ_GRANT, CCA_REQ_GRANT, READY_TO_GO, WRITEBACK_T2, PAGE_REFILL_T4;
   logic MEM_START, MEM_WRITE, PT_WRITE, EBOX_DONE, CHAN_DONE, CCA_DONE, PAGE_FAIL, NXM_ERR, BUSY;
   logic [1:0] OWNER;
   logic [3:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int starve_m = 0;
   logic [OW-1:0] exp_q[$];
   bit ack_at[MAXC];
   bit beat_at[MAXC];
   bit pm_at[MAXC];

   csh_cyc_arb #(.FILL_WORDS(4), .STARVE_LIMIT(STARVE_LIMIT), .MEM_TIMEOUT(255)) dut (
      .CLK(CLK), .RESET_n(RESET_n),
      .EBOX_REQ(EBOX_REQ), .CHAN_REQ(CHAN_REQ), .CCA_REQ(CCA_REQ),
      .CSH_HIT(CSH_HIT), .VICTIM_DIRTY(VICTIM_DIRTY), .PAGE_MISS(PAGE_MISS),
      .MEM_ACK(MEM_ACK), .MEM_DATA_VALID(MEM_DATA_VALID),
      .EBOX_REQ_GRANT(EBOX_REQ_GRANT), .CHAN_REQ_GRANT(CHAN_REQ_GRANT), .CCA_REQ_GRANT(CCA_REQ_GRANT),
      .READY_TO_GO(READY_TO_GO), .WRITEBACK_T2(WRITEBACK_T2), .PAGE_REFILL_T4(PAGE_REFILL_T4),
      .MEM_START(MEM_START), .MEM_WRITE(MEM_WRITE), .PT_WRITE(PT_WRITE),
      .EBOX_DONE(EBOX_DONE), .CHAN_DONE(CHAN_DONE), .CCA_DONE(CCA_DONE),
      .PAGE_FAIL(PAGE_FAIL), .NXM_ERR(NXM_ERR), .BUSY(BUSY), .OWNER(OWNER),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
      end
   endtask

   function automatic logic [OW-1:0] sample_out();
      return {EBOX_REQ_GRANT, CHAN_REQ_GRANT, CCA_REQ_GRANT, READY_TO_GO, WRITEBACK_T2,
              PAGE_REFILL_T4, MEM_START, MEM_WRITE & MEM_START, PT_WRITE, EBOX_DONE,
              CHAN_DONE, CCA_DONE, PAGE_FAIL, NXM_ERR, BUSY, OWNER};
   endfunction

   // arbitration reference: CHAN first, then CCA if EBOX absent or starved out, then EBOX
   task automatic arb_pick(output logic [1:0] own);
      if (!CCA_REQ) starve_m = 0;
      own = OWN_NONE;
      if (CHAN_REQ) own = OWN_CHAN;
      else if (CCA_REQ && (!EBOX_REQ || starve_m == STARVE_LIMIT)) begin
         own = OWN_CCA;
         starve_m = 0;
      end else if (EBOX_REQ) begin
         own = OWN_EBOX;
         if (CCA_REQ) starve_m++;
      end
   endtask

   task automatic drop_req(input logic [1:0] own);
      case (own)
         OWN_EBOX: EBOX_REQ = 1'b0;
         OWN_CHAN: CHAN_REQ = 1'b0;
         OWN_CCA:  begin CCA_REQ = 1'b0; starve_m = 0; end
         default: ;
      endcase
   endtask

   // Timeline of one cycle: index 0 is the IDLE cycle in which the request is arbitrated.
   task automatic model_txn(input logic [1:0] own, input bit hit, input bit dirty, input bit pm,
                            input bit fix, input bit silent);
      logic [OW-1:0] v[MAXC];
      int l, s, done_c, t, cum;
      bit retry, pm_drv, pfail, nxm;
      for (int i = 0; i < MAXC; i++) begin
         v[i] = '0; ack_at[i] = 1'b0; beat_at[i] = 1'b0; pm_at[i] = 1'b0;
      end
      ack_at[0] = 1'($urandom_range(0, 1));
      beat_at[1] = 1'($urandom_range(0, 1));
      ack_at[1] = 1'($urandom_range(0, 1));
      l = 2; s = -1; done_c = -1; retry = 0; pfail = 0; nxm = 0; pm_drv = pm;
      case (own)
         OWN_EBOX: v[1][B_EG] = 1'b1;
         OWN_CHAN: v[1][B_CG] = 1'b1;
         default:  v[1][B_AG] = 1'b1;
      endcase
      v[1][B_RTG] = 1'b1;
      while (done_c < 0) begin
         pm_at[l] = pm_drv;
         if (own == OWN_EBOX && pm_drv) begin
            if (retry) begin
               pfail = 1; done_c = l + 1;
            end else begin
               t = $urandom_range(0, 3);
               v[l+4][B_RF] = 1'b1; v[l+4][B_MS] = 1'b1;
               beat_at[l+5+t] = 1'b1;
               v[l+6+t][B_PT] = 1'b1;
               l = l + 7 + t; retry = 1; pm_drv = pm && !fix;
            end
         end else if (hit) begin
            done_c = l + 1;
         end else if (dirty) begin
            t = $urandom_range(0, 4);
            v[l+2][B_WB] = 1'b1; v[l+2][B_MS] = 1'b1; v[l+2][B_MW] = 1'b1;
            ack_at[l+3+t] = 1'b1;
            if (own == OWN_CCA) done_c = l + 4 + t;
            else s = l + 4 + t;
         end else if (own == OWN_CCA) begin
            done_c = l + 1;
         end else begin
            s = l + 1;
         end
         if (s >= 0) begin
            v[s][B_MS] = 1'b1;
            if (silent) begin
               nxm = 1; done_c = s + 255;
            end else begin
               cum = s;
               for (int k = 0; k < 4; k++) begin
                  cum += $urandom_range(1, 3);
                  beat_at[cum] = 1'b1;
               end
               done_c = cum + 1;
            end
         end
      end
      case (own)
         OWN_EBOX: v[done_c][B_ED] = 1'b1;
         OWN_CHAN: v[done_c][B_CD] = 1'b1;
         default:  v[done_c][B_AD] = 1'b1;
      endcase
      v[done_c][B_PF] = pfail;
      v[done_c][B_NX] = nxm;
      for (int c = 1; c <= done_c; c++) begin
         v[c][B_BUSY] = 1'b1;
         v[c][1:0] = own;
      end
      for (int c = 0; c <= done_c; c++) exp_q.push_back(v[c]);
   endtask

   // driver: entered and left at posedge+1 of an IDLE cycle
   task automatic run_txn(input bit hit, input bit dirty, input bit pm, input bit fix,
                          input bit silent, input bit drop_early, output logic [1:0] own);
      logic [OW-1:0] e;
      arb_pick(own);
      model_txn(own, hit, dirty, pm, fix, silent);
      for (int c = 0; exp_q.size() > 0; c++) begin
         CSH_HIT = hit; VICTIM_DIRTY = dirty;
         MEM_ACK = ack_at[c]; MEM_DATA_VALID = beat_at[c]; PAGE_MISS = pm_at[c];
         if (drop_early && c == 3) drop_req(own);
         @(negedge CLK);
         e = exp_q.pop_front();
         check($sformatf("own%0d cyc%0d", own, c), 32'(sample_out()), 32'(e));
         @(posedge CLK);
         #1;
      end
      MEM_ACK = 1'b0; MEM_DATA_VALID = 1'b0; PAGE_MISS = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         check("idle", 32'(sample_out()), 32'd0);
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      logic [1:0] own;
      bit seen;
      RESET_n = 1'b0;
      EBOX_REQ = 0; CHAN_REQ = 0; CCA_REQ = 0; CSH_HIT = 0; VICTIM_DIRTY = 0;
      PAGE_MISS = 0; MEM_ACK = 0; MEM_DATA_VALID = 0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("reset_state", 32'(sample_out()), 32'd0);
      @(posedge CLK);
      #1 RESET_n = 1'b1;
      idle_cycles(2);

      // same-cycle EBOX and CHAN, both hit
      EBOX_REQ = 1; CHAN_REQ = 1;
      run_txn(1, 0, 0, 0, 0, 0, own); drop_req(own);
      run_txn(1, 0, 0, 0, 0, 0, own); drop_req(own);
      idle_cycles(1);

      // dirty miss with writeback then fill
      EBOX_REQ = 1;
      run_txn(0, 1, 0, 0, 0, 0, own); drop_req(own);
      // page refill, retry hits; then page miss persists
      EBOX_REQ = 1;
      run_txn(1, 0, 1, 1, 0, 0, own); drop_req(own);
      EBOX_REQ = 1;
      run_txn(1, 0, 1, 0, 0, 0, own); drop_req(own);
      // CCA dirty sweep ends at the ack, CCA clean miss ends at lookup
      CCA_REQ = 1;
      run_txn(0, 1, 0, 0, 0, 0, own); drop_req(own);
      CCA_REQ = 1;
      run_txn(0, 0, 0, 0, 0, 0, own); drop_req(own);
      idle_cycles(1);

      // starvation: EBOX and CCA held, all hits
      EBOX_REQ = 1; CCA_REQ = 1;
      for (int i = 0; i < 10; i++) begin
         run_txn(1, 0, 0, 0, 0, 0, own);
         if (own == OWN_CCA) drop_req(own);
      end
      drop_req(OWN_EBOX); drop_req(OWN_CCA);
      idle_cycles(1);

      // fill with no data returned
      EBOX_REQ = 1;
      run_txn(0, 0, 0, 0, 1, 0, own); drop_req(own);
      idle_cycles(1);

      // randomized mix
      for (int n = 0; n < 40; n++) begin
         if (!EBOX_REQ && $urandom_range(0, 1) == 1) EBOX_REQ = 1;
         if (!CHAN_REQ && $urandom_range(0, 2) == 0) CHAN_REQ = 1;
         if (!CCA_REQ && $urandom_range(0, 1) == 1) CCA_REQ = 1;
         if (!EBOX_REQ && !CHAN_REQ && !CCA_REQ) EBOX_REQ = 1;
         run_txn(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 0,
                 1'($urandom_range(0, 3) == 0), own);
         drop_req(own);
      end
      drop_req(OWN_EBOX); drop_req(OWN_CHAN); drop_req(OWN_CCA);
      idle_cycles(1);

      // reset during the fill wait abandons the cycle
      EBOX_REQ = 1; CSH_HIT = 0; VICTIM_DIRTY = 0;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge CLK);
         if (MEM_START) seen = 1;
         else begin
            @(posedge CLK);
            #1;
         end
      end
      check("fill_start_seen", 32'(seen), 32'd1);
      #2 RESET_n = 1'b0;
      #1 check("reset_async", 32'(sample_out()), 32'd0);
      EBOX_REQ = 0;
      starve_m = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         check("reset_hold", 32'(sample_out()), 32'd0);
      end
      @(posedge CLK);
      #1 RESET_n = 1'b1;
      idle_cycles(1);
      CHAN_REQ = 1;
      run_txn(1, 0, 0, 0, 0, 0, own); drop_req(own);
      idle_cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
